// File: rtl/hyper_async_chan_src.sv
// Source (write) half of a Gray-pointer asynchronous channel: owns the FIFO storage and
// the write pointer, and synchronizes the destination's read pointer for flow control.
module hyper_async_chan_src #(
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned LogDepth   = 3,
  parameter int unsigned SyncStages = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 src_valid_i,
  output logic                                 src_ready_o,
  input  logic [DataWidth-1:0]                 src_data_i,
  output logic [(2**LogDepth)*DataWidth-1:0]   async_data_o,
  output logic [LogDepth:0]                    async_wptr_o,
  input  logic [LogDepth:0]                    async_rptr_i,
  output logic [LogDepth:0]                    fill_o
);

  localparam int unsigned Depth    = 2 ** LogDepth;
  localparam int unsigned PtrWidth = LogDepth + 1;

  typedef logic [PtrWidth-1:0] ptr_t;

  // Full when the Gray write pointer equals the read pointer with its top two bits inverted.
  localparam ptr_t FullMask = ptr_t'(3) << (LogDepth - 1);

  function automatic ptr_t bin2gray(ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(ptr_t g);
    ptr_t b;
    b = g;
    for (int i = int'(PtrWidth) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  ptr_t                                  wptr_q;
  ptr_t                                  wptr_gray_q;
  logic [SyncStages-1:0][PtrWidth-1:0]   sync_q;
  logic [DataWidth-1:0]                  mem_q [Depth];

  ptr_t                                  rptr_sync;
  ptr_t                                  wptr_next;
  logic [LogDepth-1:0]                   widx;
  logic                                  full;
  logic                                  push;

  assign rptr_sync   = sync_q[SyncStages-1];
  assign wptr_next   = wptr_q + ptr_t'(1);
  assign widx        = wptr_q[LogDepth-1:0];
  assign full        = (wptr_gray_q == (rptr_sync ^ FullMask));
  assign push        = src_valid_i & ~full;

  assign src_ready_o  = ~full;
  assign async_wptr_o = wptr_gray_q;
  assign fill_o       = wptr_q - gray2bin(rptr_sync);

  // Write pointer, binary and registered Gray copy, advance together on a handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q      <= '0;
      wptr_gray_q <= '0;
    end else if (push) begin
      wptr_q      <= wptr_next;
      wptr_gray_q <= bin2gray(wptr_next);
    end
  end

  // Plain flop chain for the asynchronous read pointer; stage 0 samples the input.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], async_rptr_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '{default: '0};
    end else if (push) begin
      mem_q[widx] <= src_data_i;
    end
  end

  for (genvar i = 0; i < Depth; i++) begin : g_flat
    assign async_data_o[i*DataWidth +: DataWidth] = mem_q[i];
  end

endmodule

// File: tb/tb_hyper_async_chan_src.sv
// Randomized bench for hyper_async_chan_src with an occupancy/queue model of the channel.
module tb_hyper_async_chan_src;

  localparam int unsigned DW    = 32;
  localparam int unsigned LD    = 3;
  localparam int unsigned SS    = 2;
  localparam int unsigned DEPTH = 8;

  logic                  clk = 1'b0;
  logic                  rst_ni = 1'b1;
  logic                  src_valid_i = 1'b0;
  logic                  src_ready_o;
  logic [DW-1:0]         src_data_i = '0;
  logic [DEPTH*DW-1:0]   async_data_o;
  logic [LD:0]           async_wptr_o;
  logic [LD:0]           async_rptr_i = '0;
  logic [LD:0]           fill_o;

  always #5 clk = ~clk;

  hyper_async_chan_src #(
    .DataWidth (DW),
    .LogDepth  (LD),
    .SyncStages(SS)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .src_valid_i (src_valid_i),
    .src_ready_o (src_ready_o),
    .src_data_i  (src_data_i),
    .async_data_o(async_data_o),
    .async_wptr_o(async_wptr_o),
    .async_rptr_i(async_rptr_i),
    .fill_o      (fill_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: unbounded beat counts; the reader count reaches the source after SS edges.
  int            wcnt;
  int            rd_cur;
  int            rs [SS];
  logic [DW-1:0] mem [DEPTH];

  function automatic logic [3:0] gray4(int n);
    int m;
    m = n % 16;
    return 4'(m ^ (m >> 1));
  endfunction

  function automatic int exp_fill();
    return wcnt - rs[SS-1];
  endfunction

  function automatic logic exp_ready();
    return exp_fill() < DEPTH;
  endfunction

  function automatic logic [DEPTH*DW-1:0] exp_flat();
    logic [DEPTH*DW-1:0] f;
    for (int i = 0; i < DEPTH; i++) f[i*DW +: DW] = mem[i];
    return f;
  endfunction

  task automatic model_reset();
    wcnt = 0;
    rd_cur = 0;
    for (int i = 0; i < SS; i++) rs[i] = 0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  endtask

  // Drive one cycle from a negedge; return at the following negedge.
  task automatic step(input logic v, input logic [DW-1:0] d);
    logic acc;
    src_valid_i  = v;
    src_data_i   = d;
    async_rptr_i = gray4(rd_cur);
    acc = v && exp_ready();
    @(posedge clk);
    if (acc) begin
      mem[wcnt % DEPTH] = d;
      wcnt++;
    end
    for (int i = SS - 1; i > 0; i--) rs[i] = rs[i-1];
    rs[0] = rd_cur;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2;
    rst_ni = 1'b0;
    src_valid_i = 1'b0;
    async_rptr_i = '0;
    model_reset();
    #1;
    n_cmp++; if (async_wptr_o !== 4'b0000) begin n_err++; $display("FAIL reset_wptr: got %b want 0000", async_wptr_o); end
    n_cmp++; if (src_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", src_ready_o); end
    n_cmp++; if (fill_o !== 4'd0) begin n_err++; $display("FAIL reset_fill: got %0d want 0", fill_o); end
    n_cmp++; if (async_data_o !== '0) begin n_err++; $display("FAIL reset_data: got %h want 0", async_data_o); end
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic test_fill_full();
    rd_cur = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, DW'(32'hA0 + i));
      n_cmp++; if (src_ready_o !== exp_ready()) begin n_err++; $display("FAIL fill_ready[%0d]: got %b want %b", i, src_ready_o, exp_ready()); end
      n_cmp++; if (fill_o !== 4'(exp_fill())) begin n_err++; $display("FAIL fill_level[%0d]: got %0d want %0d", i, fill_o, exp_fill()); end
      n_cmp++; if (async_wptr_o !== gray4(wcnt)) begin n_err++; $display("FAIL fill_wptr[%0d]: got %b want %b", i, async_wptr_o, gray4(wcnt)); end
    end
    n_cmp++; if (async_data_o !== exp_flat()) begin n_err++; $display("FAIL full_data: got %h want %h", async_data_o, exp_flat()); end
    n_cmp++; if (async_wptr_o !== 4'b1100) begin n_err++; $display("FAIL full_wptr: got %b want 1100", async_wptr_o); end
    n_cmp++; if (fill_o !== 4'd8) begin n_err++; $display("FAIL full_fill: got %0d want 8", fill_o); end
    n_cmp++; if (src_ready_o !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b want 0", src_ready_o); end
  endtask

  task automatic test_drain_latency();
    rd_cur = 1;
    step(1'b0, '0);
    n_cmp++; if (src_ready_o !== 1'b0) begin n_err++; $display("FAIL drain_ready_1cyc: got %b want 0", src_ready_o); end
    step(1'b0, '0);
    n_cmp++; if (src_ready_o !== 1'b1) begin n_err++; $display("FAIL drain_ready_2cyc: got %b want 1", src_ready_o); end
    n_cmp++; if (fill_o !== 4'd7) begin n_err++; $display("FAIL drain_fill: got %0d want 7", fill_o); end
    step(1'b1, DW'(32'hB0));
    n_cmp++; if (async_data_o[DW-1:0] !== DW'(32'hB0)) begin n_err++; $display("FAIL drain_entry0: got %h want b0", async_data_o[DW-1:0]); end
    n_cmp++; if (async_wptr_o !== 4'b1101) begin n_err++; $display("FAIL drain_wptr: got %b want 1101", async_wptr_o); end
    n_cmp++; if (async_data_o !== exp_flat()) begin n_err++; $display("FAIL drain_data: got %h want %h", async_data_o, exp_flat()); end
  endtask

  task automatic test_hold_not_ready();
    for (int i = 0; i < 8; i++) begin
      step(1'(i % 2 == 0), DW'($urandom));
      n_cmp++; if (async_wptr_o !== 4'b1101) begin n_err++; $display("FAIL hold_wptr[%0d]: got %b want 1101", i, async_wptr_o); end
      n_cmp++; if (async_data_o !== exp_flat()) begin n_err++; $display("FAIL hold_data[%0d]: got %h want %h", i, async_data_o, exp_flat()); end
      n_cmp++; if (src_ready_o !== 1'b0) begin n_err++; $display("FAIL hold_ready[%0d]: got %b want 0", i, src_ready_o); end
    end
  endtask

  task automatic test_stream();
    int         lag_q[$];
    int         wraps;
    int         cyc;
    logic [3:0] prev;
    test_reset();
    wraps = 0;
    cyc = 0;
    prev = async_wptr_o;
    while (wcnt < 40 && cyc < 400) begin
      if (lag_q.size() == 3) rd_cur = lag_q.pop_front();
      step(1'($urandom_range(0, 3) != 0), DW'($urandom));
      lag_q.push_back(wcnt);
      cyc++;
      n_cmp++; if (async_wptr_o !== gray4(wcnt)) begin n_err++; $display("FAIL stream_wptr[%0d]: got %b want %b", cyc, async_wptr_o, gray4(wcnt)); end
      n_cmp++; if ($countones(async_wptr_o ^ prev) > 1) begin n_err++; $display("FAIL stream_gray_step[%0d]: got %b after %b want one-bit change", cyc, async_wptr_o, prev); end
      n_cmp++; if (fill_o !== 4'(exp_fill())) begin n_err++; $display("FAIL stream_fill[%0d]: got %0d want %0d", cyc, fill_o, exp_fill()); end
      n_cmp++; if (src_ready_o !== exp_ready()) begin n_err++; $display("FAIL stream_ready[%0d]: got %b want %b", cyc, src_ready_o, exp_ready()); end
      n_cmp++; if (async_data_o !== exp_flat()) begin n_err++; $display("FAIL stream_data[%0d]: got %h want %h", cyc, async_data_o, exp_flat()); end
      if (prev == 4'b1000 && async_wptr_o == 4'b0000) wraps++;
      prev = async_wptr_o;
    end
    n_cmp++; if (wcnt != 40) begin n_err++; $display("FAIL stream_timeout: got %0d beats want 40", wcnt); end
    n_cmp++; if (wraps != 2) begin n_err++; $display("FAIL stream_wraps: got %0d want 2", wraps); end
  endtask

  task automatic test_reset_mid();
    test_reset();
    rd_cur = 0;
    for (int i = 0; i < 5; i++) step(1'b1, DW'($urandom));
    n_cmp++; if (fill_o !== 4'd5) begin n_err++; $display("FAIL mid_fill_pre: got %0d want 5", fill_o); end
    @(posedge clk);
    #2;
    rst_ni = 1'b0;
    #1;
    n_cmp++; if (async_wptr_o !== 4'b0000) begin n_err++; $display("FAIL mid_rst_wptr: got %b want 0000", async_wptr_o); end
    n_cmp++; if (async_data_o !== '0) begin n_err++; $display("FAIL mid_rst_data: got %h want 0", async_data_o); end
    n_cmp++; if (src_ready_o !== 1'b1) begin n_err++; $display("FAIL mid_rst_ready: got %b want 1", src_ready_o); end
    n_cmp++; if (fill_o !== 4'd0) begin n_err++; $display("FAIL mid_rst_fill: got %0d want 0", fill_o); end
    model_reset();
    src_valid_i = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    step(1'b1, DW'(32'hC0));
    n_cmp++; if (async_data_o[DW-1:0] !== DW'(32'hC0)) begin n_err++; $display("FAIL first_edge_entry0: got %h want c0", async_data_o[DW-1:0]); end
    n_cmp++; if (async_wptr_o !== 4'b0001) begin n_err++; $display("FAIL first_edge_wptr: got %b want 0001", async_wptr_o); end
    n_cmp++; if (fill_o !== 4'd1) begin n_err++; $display("FAIL first_edge_fill: got %0d want 1", fill_o); end
  endtask

  task automatic test_rptr_toggle();
    logic [3:0] ga;
    logic [3:0] gb;
    ga = gray4(2);
    gb = gray4(3);
    for (int i = 0; i < 5; i++) step(1'b1, DW'($urandom));
    n_cmp++; if (fill_o !== 4'd6) begin n_err++; $display("FAIL toggle_fill_pre: got %0d want 6", fill_o); end
    src_valid_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #($urandom_range(1, 3));
      async_rptr_i = ($urandom_range(0, 1) != 0) ? ga : gb;
      @(posedge clk);
      #1;
      n_cmp++;
      if (!(fill_o == 4'd6 || fill_o == 4'd4 || fill_o == 4'd3) || fill_o > 4'd8) begin
        n_err++; $display("FAIL toggle_fill[%0d]: got %0d want one of 6/4/3", i, fill_o);
      end
      n_cmp++; if (src_ready_o !== 1'b1) begin n_err++; $display("FAIL toggle_ready[%0d]: got %b want 1", i, src_ready_o); end
      #($urandom_range(1, 2));
      async_rptr_i = ($urandom_range(0, 1) != 0) ? ga : gb;
      @(negedge clk);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill_full();
    test_drain_latency();
    test_hold_not_ready();
    test_stream();
    test_reset_mid();
    test_rptr_toggle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
